// File: rtl/axis_coeff_pack_pkg.sv
// axis_coeff_pack_pkg: shared widths and lane type for the coefficient packer
package axis_coeff_pack_pkg;
    localparam int COEFF_BITS   = 32;
    localparam int HOST_BITS    = 512;
    localparam int COEFF_LANES  = HOST_BITS / COEFF_BITS;
    localparam int COEFF_LANE_W = $clog2(COEFF_LANES);
    typedef logic [COEFF_LANE_W-1:0] coeff_lane_t;
endpackage

// File: rtl/axis_coeff_pack_if.sv
// axis_coeff_pack_if: AXI-Stream bundle (tdata/tkeep/tlast/tvalid/tready) of configurable width
interface axis_coeff_pack_if
    import axis_coeff_pack_pkg::*;
#(
    parameter int DATA_BITS = COEFF_BITS
) ();
    logic [DATA_BITS-1:0]   tdata;
    logic [DATA_BITS/8-1:0] tkeep;
    logic                   tlast;
    logic                   tvalid;
    logic                   tready;

    modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_coeff_pack.sv
// axis_coeff_pack: packs 32-bit coefficients into 512-bit host beats, flushes on tlast, counts beats per packet.
// Optional build macro COEFF_PACK_ZERO_PAD_EN: partial beats present all-ones tkeep (unfilled lanes stay zero data).
module axis_coeff_pack
    import axis_coeff_pack_pkg::*;
#(
    parameter int IN_BITS  = COEFF_BITS,
    parameter int OUT_BITS = HOST_BITS
) (
    input  logic                aclk,
    input  logic                aresetn,
    axis_coeff_pack_if.slave    s_axis,
    axis_coeff_pack_if.master   m_axis,
    output logic [31:0]         pkt_beats,
    output logic                pkt_done
);
    localparam int LANES    = OUT_BITS / IN_BITS;
    localparam int LANE_W   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int IN_KEEP  = IN_BITS / 8;
    localparam int OUT_KEEP = OUT_BITS / 8;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    logic [OUT_BITS-1:0] r_acc_data;
    logic [OUT_KEEP-1:0] r_acc_keep;
    logic [LANE_W-1:0]   r_lane;
    logic [OUT_BITS-1:0] r_m_data;
    logic [OUT_KEEP-1:0] r_m_keep;
    logic                r_m_last;
    logic                r_m_valid;
    logic [31:0]         r_beat_cnt;
    logic [31:0]         r_pkt_beats;
    logic                r_pkt_done;

    logic [OUT_BITS-1:0] w_acc_data;
    logic [OUT_KEEP-1:0] w_acc_keep;
    logic [OUT_KEEP-1:0] w_out_keep;
    logic                w_commit_word;
    logic                w_accept;
    logic                w_out_hs;

    // A word that completes a beat may only enter when the output register is empty or draining this cycle.
    assign w_commit_word  = (r_lane == LAST_LANE) || s_axis.tlast;
    assign s_axis.tready  = !(w_commit_word && r_m_valid && !m_axis.tready);
    assign w_accept       = s_axis.tvalid && s_axis.tready;
    assign w_out_hs       = r_m_valid && m_axis.tready;

    assign m_axis.tdata   = r_m_data;
    assign m_axis.tkeep   = r_m_keep;
    assign m_axis.tlast   = r_m_last;
    assign m_axis.tvalid  = r_m_valid;
    assign pkt_beats      = r_pkt_beats;
    assign pkt_done       = r_pkt_done;

    // Accumulator view with the incoming word already merged into its lane.
    always_comb begin
        w_acc_data = r_acc_data;
        w_acc_keep = r_acc_keep;
        w_acc_data[IN_BITS*int'(r_lane) +: IN_BITS] = s_axis.tdata;
        w_acc_keep[IN_KEEP*int'(r_lane) +: IN_KEEP] = s_axis.tkeep;
`ifdef COEFF_PACK_ZERO_PAD_EN
        w_out_keep = (r_lane == LAST_LANE) ? w_acc_keep : '1;
`else
        w_out_keep = w_acc_keep;
`endif
    end

    // Lane accumulator: fill on accept, clear once the beat is handed to the output register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_acc_data <= '0;
            r_acc_keep <= '0;
            r_lane     <= '0;
        end else if (w_accept) begin
            r_acc_data <= w_commit_word ? '0 : w_acc_data;
            r_acc_keep <= w_commit_word ? '0 : w_acc_keep;
            r_lane     <= w_commit_word ? '0 : r_lane + LANE_W'(1);
        end
    end

    // Output register: loads on commit (also in the cycle the held beat drains), otherwise holds until taken.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_m_data  <= '0;
            r_m_keep  <= '0;
            r_m_last  <= 1'b0;
            r_m_valid <= 1'b0;
        end else if (w_accept && w_commit_word) begin
            r_m_data  <= w_acc_data;
            r_m_keep  <= w_out_keep;
            r_m_last  <= s_axis.tlast;
            r_m_valid <= 1'b1;
        end else if (m_axis.tready) begin
            r_m_valid <= 1'b0;
        end
    end

    // Beat counter: per-packet count published with a one-cycle done pulse after the tlast beat drains.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_beat_cnt  <= '0;
            r_pkt_beats <= '0;
            r_pkt_done  <= 1'b0;
        end else begin
            r_pkt_done <= w_out_hs && r_m_last;
            if (w_out_hs && r_m_last) begin
                r_pkt_beats <= r_beat_cnt + 32'd1;
                r_beat_cnt  <= '0;
            end else if (w_out_hs) begin
                r_beat_cnt  <= r_beat_cnt + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_axis_coeff_pack.sv
// tb_axis_coeff_pack: scoreboard bench for the coefficient packer
module tb_axis_coeff_pack;
    typedef struct packed {
        logic [511:0] d;
        logic [63:0]  k;
        logic         l;
    } beat_t;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] pkt_beats;
    logic        pkt_done;

    axis_coeff_pack_if #(.DATA_BITS(32))  s_if ();
    axis_coeff_pack_if #(.DATA_BITS(512)) m_if ();

    axis_coeff_pack dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_axis    (s_if),
        .m_axis    (m_if),
        .pkt_beats (pkt_beats),
        .pkt_done  (pkt_done)
    );

    always #5 aclk = ~aclk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    beat_t exp_q[$];
    int pkt_q[$];
    int hs_q[$];
    beat_t mon_e;
    logic [511:0] md = '0;
    logic [63:0]  mk = '0;
    int ml = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    // monitor: compare every output handshake against the scoreboard, log pkt_done pulses
    always @(negedge aclk) begin
        if (m_if.tvalid && m_if.tready) begin
            hs_q.push_back(cyc);
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL beat_unexpected: got data=%h last=%b, required no beat", m_if.tdata, m_if.tlast);
            end else begin
                mon_e = exp_q.pop_front();
                if (m_if.tdata !== mon_e.d || m_if.tkeep !== mon_e.k || m_if.tlast !== mon_e.l) begin
                    miscompares++;
                    $display("FAIL beat: got d=%h k=%h l=%b, required d=%h k=%h l=%b",
                             m_if.tdata, m_if.tkeep, m_if.tlast, mon_e.d, mon_e.k, mon_e.l);
                end
            end
        end
        if (pkt_done) pkt_q.push_back(int'(pkt_beats));
    end

    task automatic model_accept(input logic [31:0] d, input logic [3:0] k, input logic l);
        beat_t b;
        md[32*ml +: 32] = d;
        mk[4*ml +: 4] = k;
        if (ml == 15 || l) begin
            b.d = md;
`ifdef COEFF_PACK_ZERO_PAD_EN
            b.k = (ml == 15) ? mk : '1;
`else
            b.k = mk;
`endif
            b.l = l;
            exp_q.push_back(b);
            md = '0;
            mk = '0;
            ml = 0;
        end else begin
            ml++;
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic l, output bit stalled);
        int t;
        bit done;
        s_if.tdata = d;
        s_if.tkeep = k;
        s_if.tlast = l;
        s_if.tvalid = 1'b1;
        stalled = 0;
        t = 0;
        done = 0;
        while (!done) begin
            @(negedge aclk);
            if (s_if.tready) done = 1;
            else begin
                stalled = 1;
                t++;
                if (t > 200) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL send_timeout: s_axis_tready=0 for %0d cycles, required 1", t);
                    done = 1;
                end
            end
        end
        @(posedge aclk);
        #1;
        if (t <= 200) model_accept(d, k, l);
    endtask

    task automatic send_pkt(input int n, input logic [31:0] base, input bit last_at_end,
                            output int first_stall, output int stall_words);
        bit st;
        first_stall = 0;
        stall_words = 0;
        for (int i = 0; i < n; i++) begin
            send_word(base + 32'(i), 4'hF, last_at_end && (i == n - 1), st);
            if (st) begin
                stall_words++;
                if (first_stall == 0) first_stall = i + 1;
            end
        end
        s_if.tvalid = 1'b0;
        s_if.tlast = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge aclk);
            #1;
            t++;
        end
        repeat (3) @(posedge aclk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        vectors += 7;
        if (s_if.tready !== 1'b1) begin miscompares++; $display("FAIL rst_s_tready: got %b, required 1", s_if.tready); end
        if (m_if.tvalid !== 1'b0) begin miscompares++; $display("FAIL rst_m_tvalid: got %b, required 0", m_if.tvalid); end
        if (m_if.tlast !== 1'b0) begin miscompares++; $display("FAIL rst_m_tlast: got %b, required 0", m_if.tlast); end
        if (m_if.tdata !== '0) begin miscompares++; $display("FAIL rst_m_tdata: got %h, required 0", m_if.tdata); end
        if (m_if.tkeep !== '0) begin miscompares++; $display("FAIL rst_m_tkeep: got %h, required 0", m_if.tkeep); end
        if (pkt_beats !== 32'd0) begin miscompares++; $display("FAIL rst_pkt_beats: got %0d, required 0", pkt_beats); end
        if (pkt_done !== 1'b0) begin miscompares++; $display("FAIL rst_pkt_done: got %b, required 0", pkt_done); end
    endtask

    task automatic test_full_beat();
        int fs, ns;
        pkt_q.delete();
        send_pkt(16, 32'h1, 1, fs, ns);
        vectors += 4;
        if (m_if.tvalid !== 1'b1 || m_if.tlast !== 1'b1) begin
            miscompares++;
            $display("FAIL full_latency: got tvalid=%b tlast=%b, required 1 1", m_if.tvalid, m_if.tlast);
        end
        if (m_if.tdata[31:0] !== 32'h1) begin miscompares++; $display("FAIL full_lane0: got %h, required 00000001", m_if.tdata[31:0]); end
        if (m_if.tdata[511:480] !== 32'h10) begin miscompares++; $display("FAIL full_lane15: got %h, required 00000010", m_if.tdata[511:480]); end
        if (m_if.tkeep !== {64{1'b1}}) begin miscompares++; $display("FAIL full_keep: got %h, required all ones", m_if.tkeep); end
        wait_drain("full");
        vectors++;
        if (pkt_q.size() != 1 || pkt_q[0] != 1) begin
            miscompares++;
            $display("FAIL full_pkt: got %0d pulses first=%0d, required 1 pulse of 1", pkt_q.size(), pkt_q.size() ? pkt_q[0] : -1);
        end
    endtask

    task automatic test_partial();
        int fs, ns;
        pkt_q.delete();
        send_pkt(20, 32'h100, 1, fs, ns);
        wait_drain("partial");
        vectors++;
        if (pkt_q.size() != 1 || pkt_q[0] != 2) begin
            miscompares++;
            $display("FAIL partial_pkt: got %0d pulses first=%0d, required 1 pulse of 2", pkt_q.size(), pkt_q.size() ? pkt_q[0] : -1);
        end
    endtask

    task automatic test_backpressure();
        int fs, ns, t;
        pkt_q.delete();
        m_if.tready = 1'b0;
        fork
            send_pkt(64, 32'h1000, 1, fs, ns);
            begin
                t = 0;
                while (!m_if.tvalid && t < 200) begin
                    @(negedge aclk);
                    t++;
                end
                repeat (40) @(posedge aclk);
                #1;
                m_if.tready = 1'b1;
            end
        join
        vectors += 2;
        if (fs != 32) begin miscompares++; $display("FAIL bp_first_stall: got word %0d, required 32", fs); end
        if (ns != 1) begin miscompares++; $display("FAIL bp_stalled_words: got %0d, required 1", ns); end
        wait_drain("bp");
        vectors++;
        if (pkt_q.size() != 1 || pkt_q[0] != 4) begin
            miscompares++;
            $display("FAIL bp_pkt: got %0d pulses first=%0d, required 1 pulse of 4", pkt_q.size(), pkt_q.size() ? pkt_q[0] : -1);
        end
    endtask

    task automatic test_single();
        bit st;
        logic [63:0] ek;
        pkt_q.delete();
`ifdef COEFF_PACK_ZERO_PAD_EN
        ek = '1;
`else
        ek = 64'hF;
`endif
        send_word(32'hDEADBEEF, 4'hF, 1'b1, st);
        s_if.tvalid = 1'b0;
        s_if.tlast = 1'b0;
        vectors += 2;
        if (m_if.tdata[31:0] !== 32'hDEADBEEF || m_if.tdata[511:32] !== '0) begin
            miscompares++;
            $display("FAIL single_data: got %h, required lane0 deadbeef others 0", m_if.tdata);
        end
        if (m_if.tkeep !== ek) begin miscompares++; $display("FAIL single_keep: got %h, required %h", m_if.tkeep, ek); end
        wait_drain("single");
        vectors++;
        if (pkt_q.size() != 1 || pkt_q[0] != 1) begin
            miscompares++;
            $display("FAIL single_pkt: got %0d pulses first=%0d, required 1 pulse of 1", pkt_q.size(), pkt_q.size() ? pkt_q[0] : -1);
        end
    endtask

    task automatic test_reset_mid();
        int fs, ns;
        send_pkt(7, 32'hA000, 0, fs, ns);
        aresetn = 1'b0;
        md = '0;
        mk = '0;
        ml = 0;
        exp_q.delete();
        #3;
        vectors++;
        if (m_if.tvalid !== 1'b0 || s_if.tready !== 1'b1 || pkt_beats !== 32'd0) begin
            miscompares++;
            $display("FAIL mid_rst_state: got tvalid=%b tready=%b pkt_beats=%0d, required 0 1 0", m_if.tvalid, s_if.tready, pkt_beats);
        end
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        pkt_q.delete();
        send_pkt(16, 32'h2000, 1, fs, ns);
        wait_drain("mid_rst");
        vectors++;
        if (pkt_q.size() != 1 || pkt_q[0] != 1) begin
            miscompares++;
            $display("FAIL mid_rst_pkt: got %0d pulses first=%0d, required 1 pulse of 1", pkt_q.size(), pkt_q.size() ? pkt_q[0] : -1);
        end
    endtask

    task automatic test_back_to_back();
        int fs, ns;
        pkt_q.delete();
        hs_q.delete();
        send_pkt(16, 32'h3000, 1, fs, ns);
        send_pkt(16, 32'h4000, 1, fs, ns);
        wait_drain("b2b");
        vectors += 2;
        if (hs_q.size() != 2 || hs_q[1] - hs_q[0] != 16) begin
            miscompares++;
            $display("FAIL b2b_slots: got %0d beats spacing %0d, required 2 beats spacing 16",
                     hs_q.size(), hs_q.size() == 2 ? hs_q[1] - hs_q[0] : -1);
        end
        if (pkt_q.size() != 2 || pkt_q[0] != 1 || pkt_q[1] != 1) begin
            miscompares++;
            $display("FAIL b2b_pkt: got %0d pulses, required 2 pulses of 1", pkt_q.size());
        end
    endtask

    initial begin
        s_if.tdata = '0;
        s_if.tkeep = '0;
        s_if.tlast = 1'b0;
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        test_reset();
        test_full_beat();
        test_partial();
        test_backpressure();
        test_single();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
